// File: rtl/ext_scale_pipe.sv
// ext_scale_pipe
//   Elastic two-stage stream unit. It widens narrow samples to OUT_W bits, using
//   sign- or zero-extension chosen per beat. It then applies an unsigned
//   fixed-point gain (1.0 == 1<<FRAC) and truncates the result back to OUT_W
//   bits, flagging any overflow.
//
//   Optional build macro: EXT_SCALE_SATURATE_EN
//     defined   : overflowing results clamp to the OUT_W range (out_ovf still set)
//     undefined : overflowing results wrap (plain truncation), out_ovf is a flag
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   input beat valid
//   in_ready   out  input accepted when in_valid && in_ready
//   in_data    in   [IN_W-1:0]   narrow sample
//   in_signed  in   1: in_data is signed, 0: unsigned
//   gain       in   [GAIN_W-1:0] unsigned gain, captured with the input beat
//   out_valid  out  output beat valid
//   out_ready  in   downstream accepts when out_valid && out_ready
//   out_data   out  [OUT_W-1:0]  scaled result
//   out_ovf    out  result did not fit in OUT_W
//   ovf_count  out  [15:0] saturating count of accepted beats with out_ovf=1
module ext_scale_pipe #(
  parameter int IN_W   = 4,
  parameter int OUT_W  = 9,
  parameter int GAIN_W = 9,
  parameter int FRAC   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IN_W-1:0]   in_data,
  input  logic              in_signed,
  input  logic [GAIN_W-1:0] gain,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_ovf,
  output logic [15:0]       ovf_count
);

  localparam int PW = OUT_W + GAIN_W;

  if (OUT_W < IN_W) begin : g_width_check
    $error("ext_scale_pipe: OUT_W must be >= IN_W");
  end

  logic              rdy_q;
  logic              s1_valid_q, s1_valid_d;
  logic [OUT_W-1:0]  s1_ext_q;
  logic              s1_signed_q;
  logic [GAIN_W-1:0] s1_gain_q;
  logic              s2_valid_q, s2_valid_d;
  logic [OUT_W-1:0]  s2_data_q;
  logic              s2_ovf_q;
  logic [15:0]       ovf_cnt_q, ovf_cnt_d;

  logic              s2_ready, in_fire, s1_adv, out_fire;
  logic [OUT_W-1:0]  ext_d;
  logic [PW-1:0]     ext_x, gain_x, prod, sh_u, shifted;
  logic signed [PW-1:0] prod_s, sh_s;
  logic [GAIN_W-1:0] upper;
  logic [OUT_W-1:0]  res_d;
  logic              ovf_d;

  // Stage 2 can take new content when empty or when its beat leaves this cycle.
  assign s2_ready = !s2_valid_q || out_ready;
  // rdy_q keeps in_ready low until the first clock after reset release.
  assign in_ready = rdy_q && (!s1_valid_q || s2_ready);
  assign in_fire  = in_valid && in_ready;
  assign s1_adv   = s1_valid_q && s2_ready;
  assign out_fire = s2_valid_q && out_ready;

  always_comb begin
    ext_d = in_signed ? OUT_W'($signed(in_data)) : OUT_W'(in_data);
  end

  // Extending both operands to the full product width makes the low PW bits
  // of an unsigned multiply equal to the signed product when in_signed=1.
  always_comb begin
    ext_x   = s1_signed_q ? PW'($signed(s1_ext_q)) : PW'(s1_ext_q);
    gain_x  = PW'(s1_gain_q);
    prod    = ext_x * gain_x;
    prod_s  = prod;
    sh_s    = prod_s >>> FRAC;
    sh_u    = prod >> FRAC;
    shifted = s1_signed_q ? sh_s : sh_u;
    upper   = shifted[PW-1:OUT_W];
    res_d   = shifted[OUT_W-1:0];
    ovf_d   = s1_signed_q ? (upper != {GAIN_W{res_d[OUT_W-1]}}) : (upper != '0);
`ifdef EXT_SCALE_SATURATE_EN
    if (ovf_d) begin
      if (!s1_signed_q)        res_d = '1;
      else if (shifted[PW-1])  res_d = {1'b1, {(OUT_W-1){1'b0}}};
      else                     res_d = {1'b0, {(OUT_W-1){1'b1}}};
    end
`endif
  end

  always_comb begin
    s1_valid_d = in_fire || (s1_valid_q && !s2_ready);
    s2_valid_d = s2_ready ? s1_valid_q : s2_valid_q;
    ovf_cnt_d  = ovf_cnt_q;
    if (out_fire && s2_ovf_q && (ovf_cnt_q != 16'hFFFF)) ovf_cnt_d = ovf_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_q       <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_ext_q    <= '0;
      s1_signed_q <= 1'b0;
      s1_gain_q   <= '0;
      s2_valid_q  <= 1'b0;
      s2_data_q   <= '0;
      s2_ovf_q    <= 1'b0;
      ovf_cnt_q   <= '0;
    end else begin
      rdy_q      <= 1'b1;
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      ovf_cnt_q  <= ovf_cnt_d;
      if (in_fire) begin
        s1_ext_q    <= ext_d;
        s1_signed_q <= in_signed;
        s1_gain_q   <= gain;
      end
      if (s1_adv) begin
        s2_data_q <= res_d;
        s2_ovf_q  <= ovf_d;
      end
    end
  end

  assign out_valid = s2_valid_q;
  assign out_data  = s2_data_q;
  assign out_ovf   = s2_ovf_q;
  assign ovf_count = ovf_cnt_q;

endmodule
